load_store_unit: RTL and testbench

Initiator-side load/store unit that turns a single core memory request (byte, half or word, signed or unsigned, any alignment) into word-aligned byte-lane accesses on the data port of the shared dual-port memory. It sits between the execute stage and memory port 1. It splits accesses that cross a word boundary into two sequential word accesses and reassembles and extends load data. It returns a one-cycle completion pulse per request.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/load_store_align.sv | 66 ++++++
 rtl/load_store_unit.sv | 154 +++++++++++++++
 tb/tb_load_store_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the request size encodings, the control FSM state type and a helper
// that maps a size encoding to its access width in bytes.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_BAD  = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StAcc1,
    StAcc2,
    StResp
  } lsu_state_e;

  // Access width in bytes; 0 for the illegal encoding.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_BYTE: n = 3'd1;
      SIZE_HALF: n = 3'd2;
      SIZE_WORD: n = 3'd4;
      default:   n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational alignment datapath for the load/store unit.
// Ports:
//   size, is_unsigned   : latched request size and extension mode
//   off                 : byte offset within the first word
//   wdata               : right-justified store data
//   word1, word2        : first and second memory words for load merging
//   mask                : 8-bit byte mask spanning both words
//   split               : access crosses a word boundary
//   wdata_lo, wdata_hi  : lane-positioned store data for each word
//   rdata               : merged and sign/zero-extended load result
module load_store_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] word1,
  input  logic [31:0] word2,
  output logic [7:0]  mask,
  output logic        split,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [31:0] rdata
);

  logic [2:0]  nbytes;
  logic [7:0]  base_mask;
  logic [4:0]  lo_shift;
  logic [5:0]  hi_shift;
  logic [31:0] raw;

  assign nbytes   = size_nbytes(size);
  assign lo_shift = {off, 3'b000};
  // Shift of 32 (off == 0) yields zero; that half is unused when not split.
  assign hi_shift = 6'd32 - {1'b0, lo_shift};

  always_comb begin
    base_mask = 8'h00;
    case (size)
      SIZE_BYTE: base_mask = 8'b0000_0001;
      SIZE_HALF: base_mask = 8'b0000_0011;
      SIZE_WORD: base_mask = 8'b0000_1111;
      default:   base_mask = 8'h00;
    endcase
  end

  assign mask     = base_mask << off;
  assign split    = ({1'b0, off} + nbytes) > 3'd4;
  assign wdata_lo = wdata << lo_shift;
  assign wdata_hi = wdata >> hi_shift;

  // Bytes from lane 'off' of word1 upward, continuing into word2 lanes 0...
  assign raw = 32'({word2, word1} >> lo_shift);

  always_comb begin
    rdata = '0;
    case (size)
      SIZE_BYTE: rdata = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
      SIZE_HALF: rdata = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
      SIZE_WORD: rdata = raw;
      default:   rdata = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: converts one core request of any size and alignment into
// one or two word-aligned byte-lane accesses on a memory data port, merges
// load data and returns a single-cycle completion pulse.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   req_valid/req_ready             : request handshake
//   req_write/size/unsigned/addr/wdata : request fields
//   resp_valid/resp_rdata/resp_error   : completion pulse and result
//   mem_addr/mem_wdata/mem_wenable  : word-aligned memory port outputs
//   mem_rdata                       : combinational read data of mem_addr
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wenable,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, wdata_q, word1_q, rdata_q;
  logic [1:0]  size_q;
  logic        unsigned_q, write_q, error_q;

  logic        handshake;
  logic [7:0]  mask;
  logic        split;
  logic [31:0] wdata_lo, wdata_hi, load_data;
  logic [31:0] word1_sel, word2_sel, word_base;

  assign handshake = req_valid && req_ready;
  assign word_base = {addr_q[31:2], 2'b00};
  // In ACC1 the first word comes straight from memory; in ACC2 it is the capture.
  assign word1_sel = (state_q == StAcc1) ? mem_rdata : word1_q;
  assign word2_sel = (state_q == StAcc2) ? mem_rdata : 32'h0;

  load_store_align u_align (
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .off         (addr_q[1:0]),
    .wdata       (wdata_q),
    .word1       (word1_sel),
    .word2       (word2_sel),
    .mask        (mask),
    .split       (split),
    .wdata_lo    (wdata_lo),
    .wdata_hi    (wdata_hi),
    .rdata       (load_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          state_d = (req_size == SIZE_BAD) ? StResp : StAcc1;
        end
      end
      StAcc1:  state_d = split ? StAcc2 : StResp;
      StAcc2:  state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request latch, first-word capture and result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      write_q    <= 1'b0;
      error_q    <= 1'b0;
      word1_q    <= '0;
      rdata_q    <= '0;
    end else begin
      if (handshake) begin
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        write_q    <= req_write;
        error_q    <= (req_size == SIZE_BAD);
        rdata_q    <= '0;
      end
      if (state_q == StAcc1) begin
        word1_q <= mem_rdata;
        if (!write_q && !split) begin
          rdata_q <= load_data;
        end
      end
      if (state_q == StAcc2 && !write_q) begin
        rdata_q <= load_data;
      end
    end
  end

  // Output logic
  always_comb begin
    req_ready   = rst_n && (state_q == StIdle);
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    resp_error  = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wenable = '0;
    unique case (state_q)
      StAcc1: begin
        mem_addr    = word_base;
        mem_wdata   = wdata_lo;
        mem_wenable = write_q ? mask[3:0] : 4'b0000;
      end
      StAcc2: begin
        mem_addr    = word_base + 32'd4;
        mem_wdata   = wdata_hi;
        mem_wenable = write_q ? mask[7:4] : 4'b0000;
      end
      StResp: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_error = error_q;
      end
      default: ;
    endcase
    // No memory write may happen in a reset cycle, even mid-access.
    if (!rst_n) begin
      mem_wenable = '0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wenable;
  logic [31:0] mem_rdata;

  logic [31:0] mem [256];
  logic        do_preload;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wenable  (mem_wenable),
    .mem_rdata    (mem_rdata)
  );

  // Word memory: byte address bits [9:2] select the word; 0x100 -> 64, 0x104 -> 65.
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (do_preload) begin
      mem[64] <= 32'h44332211;
      mem[65] <= 32'h88776655;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wenable[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic preload();
    @(negedge clk);
    do_preload = 1'b1;
    @(negedge clk);
    do_preload = 1'b0;
  endtask

  // Presents a request, completes the handshake on the next edge and returns
  // in the middle of cycle N+1.
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = d;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL issue_ready got=%b want=1", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'd2;
    req_addr  = 32'h100;
    req_wdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b want=0", resp_valid); end
    total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", resp_rdata); end
    total++; if (resp_error !== 1'b0) begin bad++; $display("FAIL rst_error got=%b want=0", resp_error); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h want=0", mem_addr); end
    total++; if (mem_wenable !== 4'h0) begin bad++; $display("FAIL rst_wen got=%b want=0", mem_wenable); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h want=0", mem_wdata); end
    req_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_release_resp got=%b want=0", resp_valid); end
  endtask

  task automatic test_byte_load();
    preload();
    issue(1'b0, 2'd0, 1'b0, 32'h107, 32'h0);
    total++; if (mem_addr !== 32'h104) begin bad++; $display("FAIL lb_addr got=%h want=104", mem_addr); end
    total++; if (mem_wenable !== 4'h0) begin bad++; $display("FAIL lb_wen got=%b want=0000", mem_wenable); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL lb_busy_ready got=%b want=0", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL lb_early_resp got=%b want=0", resp_valid); end
    @(negedge clk);
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL lb_resp got=%b want=1", resp_valid); end
    total++; if (resp_rdata !== 32'hFFFFFF88) begin bad++; $display("FAIL lb_data got=%h want=ffffff88", resp_rdata); end
    total++; if (resp_error !== 1'b0) begin bad++; $display("FAIL lb_error got=%b want=0", resp_error); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL lb_resp_addr got=%h want=0", mem_addr); end
    issue(1'b0, 2'd0, 1'b1, 32'h107, 32'h0);
    @(negedge clk);
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL lbu_resp got=%b want=1", resp_valid); end
    total++; if (resp_rdata !== 32'h00000088) begin bad++; $display("FAIL lbu_data got=%h want=00000088", resp_rdata); end
    @(negedge clk);
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL lbu_pulse got=%b want=0", resp_valid); end
  endtask

  task automatic test_split_load();
    preload();
    issue(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL lw_split_addr1 got=%h want=100", mem_addr); end
    @(negedge clk);
    total++; if (mem_addr !== 32'h104) begin bad++; $display("FAIL lw_split_addr2 got=%h want=104", mem_addr); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL lw_split_early got=%b want=0", resp_valid); end
    @(negedge clk);
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL lw_split_resp got=%b want=1", resp_valid); end
    total++; if (resp_rdata !== 32'h66554433) begin bad++; $display("FAIL lw_split_data got=%h want=66554433", resp_rdata); end
  endtask

  task automatic test_half_store();
    preload();
    issue(1'b1, 2'd1, 1'b0, 32'h101, 32'h0000BEEF);
    total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL sh_addr got=%h want=100", mem_addr); end
    total++; if (mem_wenable !== 4'b0110) begin bad++; $display("FAIL sh_wen got=%b want=0110", mem_wenable); end
    total++; if (mem_wdata !== 32'h00BEEF00) begin bad++; $display("FAIL sh_wdata got=%h want=00beef00", mem_wdata); end
    @(negedge clk);
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL sh_resp got=%b want=1", resp_valid); end
    total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL sh_rdata got=%h want=0", resp_rdata); end
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    total++; if (resp_rdata !== 32'h44BEEF11) begin bad++; $display("FAIL sh_readback got=%h want=44beef11", resp_rdata); end
  endtask

  task automatic test_split_store();
    preload();
    issue(1'b1, 2'd2, 1'b0, 32'h103, 32'hDEADBEEF);
    total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL sw_split_addr1 got=%h want=100", mem_addr); end
    total++; if (mem_wenable !== 4'b1000) begin bad++; $display("FAIL sw_split_wen1 got=%b want=1000", mem_wenable); end
    total++; if (mem_wdata !== 32'hEF000000) begin bad++; $display("FAIL sw_split_wdata1 got=%h want=ef000000", mem_wdata); end
    @(negedge clk);
    total++; if (mem_addr !== 32'h104) begin bad++; $display("FAIL sw_split_addr2 got=%h want=104", mem_addr); end
    total++; if (mem_wenable !== 4'b0111) begin bad++; $display("FAIL sw_split_wen2 got=%b want=0111", mem_wenable); end
    total++; if (mem_wdata !== 32'h00DEADBE) begin bad++; $display("FAIL sw_split_wdata2 got=%h want=00deadbe", mem_wdata); end
    @(negedge clk);
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL sw_split_resp got=%b want=1", resp_valid); end
    total++; if (mem[64] !== 32'hEF332211) begin bad++; $display("FAIL sw_split_mem0 got=%h want=ef332211", mem[64]); end
    total++; if (mem[65] !== 32'h88DEADBE) begin bad++; $display("FAIL sw_split_mem1 got=%h want=88deadbe", mem[65]); end
  endtask

  task automatic test_reset_split_store();
    preload();
    issue(1'b1, 2'd2, 1'b0, 32'h103, 32'hDEADBEEF);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    total++; if (mem_wenable !== 4'h0) begin bad++; $display("FAIL rsplit_wen got=%b want=0", mem_wenable); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rsplit_resp got=%b want=0", resp_valid); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rsplit_ready got=%b want=0", req_ready); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rsplit_release_ready got=%b want=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rsplit_no_resp got=%b want=0", resp_valid); end
    total++; if (mem[64] !== 32'hEF332211) begin bad++; $display("FAIL rsplit_mem0 got=%h want=ef332211", mem[64]); end
    total++; if (mem[65] !== 32'h88776655) begin bad++; $display("FAIL rsplit_mem1 got=%h want=88776655", mem[65]); end
  endtask

  task automatic test_illegal_size();
    preload();
    issue(1'b1, 2'd3, 1'b0, 32'h100, 32'hFFFFFFFF);
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL ill_resp got=%b want=1", resp_valid); end
    total++; if (resp_error !== 1'b1) begin bad++; $display("FAIL ill_error got=%b want=1", resp_error); end
    total++; if (mem_wenable !== 4'h0) begin bad++; $display("FAIL ill_wen got=%b want=0", mem_wenable); end
    total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL ill_rdata got=%h want=0", resp_rdata); end
    @(negedge clk);
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL ill_pulse got=%b want=0", resp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL ill_ready got=%b want=1", req_ready); end
    total++; if (mem[64] !== 32'h44332211) begin bad++; $display("FAIL ill_mem got=%h want=44332211", mem[64]); end
  endtask

  initial begin
    do_preload   = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    test_reset();
    test_byte_load();
    test_split_load();
    test_half_store();
    test_split_store();
    test_reset_split_store();
    test_illegal_size();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
